// File: rtl/prsim_reset_sequencer.sv
// Reset/lock sequencer for a PRS-simulated oscillator: holds _Reset low, releases it,
// counts synchronized osc edges to declare lock, and retries on a stalled oscillator.
module prsim_reset_sequencer #(
  parameter int RESET_CYCLES = 4,
  parameter int LOCK_EDGES   = 8,
  parameter int WATCHDOG     = 64,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       osc,
  output logic       _Reset,
  output logic       locked,
  output logic       fail,
  output logic       busy,
  output logic [7:0] edge_count,
  output logic [3:0] retry_count
);

  localparam logic [7:0]  HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0]  LOCK_TGT  = 8'(LOCK_EDGES);
  localparam logic [15:0] WD_LAST   = 16'(WATCHDOG - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    LOCKED,
    FAIL
  } state_t;

  state_t      state;
  logic        osc_sync1;
  logic        osc_sync2;
  logic        osc_hist;
  logic        osc_edge;
  logic [7:0]  hold_cnt;
  logic [15:0] wd_cnt;
  logic [7:0]  edge_count_inc;

  // osc is asynchronous; the history flop lets both polarities register as one edge each
  always_ff @(posedge clk) begin
    if (reset) begin
      osc_sync1 <= 1'b0;
      osc_sync2 <= 1'b0;
      osc_hist  <= 1'b0;
    end else begin
      osc_sync1 <= osc;
      osc_sync2 <= osc_sync1;
      osc_hist  <= osc_sync2;
    end
  end

  assign osc_edge       = osc_sync2 ^ osc_hist;
  assign edge_count_inc = (edge_count == 8'hFF) ? edge_count : edge_count + 8'd1;

  always_ff @(posedge clk) begin
    if (reset || stop) begin
      state       <= IDLE;
      _Reset      <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      busy        <= 1'b0;
      edge_count  <= 8'd0;
      retry_count <= 4'd0;
      hold_cnt    <= 8'd0;
      wd_cnt      <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= HOLD;
            busy        <= 1'b1;
            retry_count <= 4'd0;
            edge_count  <= 8'd0;
            wd_cnt      <= 16'd0;
            hold_cnt    <= 8'd0;
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state  <= RUN;
            _Reset <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        // An edge on the same cycle the watchdog would expire keeps the oscillator alive
        RUN, LOCKED: begin
          if (osc_edge) begin
            edge_count <= edge_count_inc;
            wd_cnt     <= 16'd0;
            if (state == RUN && edge_count_inc >= LOCK_TGT) begin
              state  <= LOCKED;
              locked <= 1'b1;
              busy   <= 1'b0;
            end
          end else if (wd_cnt == WD_LAST) begin
            if (retry_count < RETRY_MAX) begin
              state       <= HOLD;
              retry_count <= retry_count + 4'd1;
              _Reset      <= 1'b0;
              locked      <= 1'b0;
              busy        <= 1'b1;
              edge_count  <= 8'd0;
              wd_cnt      <= 16'd0;
              hold_cnt    <= 8'd0;
            end else begin
              state  <= FAIL;
              _Reset <= 1'b0;
              locked <= 1'b0;
              fail   <= 1'b1;
              busy   <= 1'b0;
            end
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end

        FAIL: begin
          if (start) begin
            state       <= HOLD;
            fail        <= 1'b0;
            busy        <= 1'b1;
            retry_count <= 4'd0;
            edge_count  <= 8'd0;
            wd_cnt      <= 16'd0;
            hold_cnt    <= 8'd0;
          end
        end

        default: begin
          state  <= IDLE;
          _Reset <= 1'b0;
          locked <= 1'b0;
          fail   <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prsim_reset_sequencer.sv
// Directed bench for prsim_reset_sequencer: a vector table for reset/start/abort basics,
// then hand-timed sequences for lock, stall-after-lock, mid-sequence reset, stuck osc and watchdog race.
module tb_prsim_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       osc;
  logic       n_reset;
  logic       locked;
  logic       fail;
  logic       busy;
  logic [7:0] edge_count;
  logic [3:0] retry_count;

  int checks = 0;
  int errors = 0;

  prsim_reset_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .osc         (osc),
    ._Reset      (n_reset),
    .locked      (locked),
    .fail        (fail),
    .busy        (busy),
    .edge_count  (edge_count),
    .retry_count (retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic        sp;
    logic        os;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[19];

  // {_Reset, locked, fail, busy, edge_count, retry_count}
  function automatic logic [15:0] pk(input logic nr, input logic lk, input logic fl,
                                     input logic by, input logic [7:0] ec, input logic [3:0] rc);
    return {nr, lk, fl, by, ec, rc};
  endfunction

  function automatic vec_t mkv(input logic rst, input logic st, input logic sp, input logic os,
                               input logic [15:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.os = os; v.exp = exp; v.name = name;
    return v;
  endfunction

  // Inputs change just after a rising edge; outputs are sampled 1 ns after the next one
  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic o);
    reset = r;
    start = s;
    stop  = p;
    osc   = o;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expected);
    logic [15:0] actual;
    actual = {n_reset, locked, fail, busy, edge_count, retry_count};
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got {nRst,lk,fl,by,ec,rc}=%h expected %h", name, actual, expected);
    end
  endtask

  initial begin
    logic oscv;
    int   lock_cyc, lock_edges;
    int   fall_cyc, fall_retry, fall_busy, fall_nr, fall_edges, relock_cyc;
    int   r1_cyc, r2_cyc, r3_cyc, fail_cyc, fail_nr, fail_busy;

    reset = 1'b1; start = 1'b0; stop = 1'b0; osc = 1'b0;

    vecs[0]  = mkv(1, 0, 0, 0, pk(0, 0, 0, 0, 8'd0, 4'd0), "por0");
    vecs[1]  = mkv(1, 0, 0, 0, pk(0, 0, 0, 0, 8'd0, 4'd0), "por1");
    vecs[2]  = mkv(0, 0, 0, 0, pk(0, 0, 0, 0, 8'd0, 4'd0), "idle");
    vecs[3]  = mkv(0, 1, 1, 0, pk(0, 0, 0, 0, 8'd0, 4'd0), "start_stop_idle");
    vecs[4]  = mkv(0, 0, 0, 0, pk(0, 0, 0, 0, 8'd0, 4'd0), "idle2");
    vecs[5]  = mkv(0, 1, 0, 0, pk(0, 0, 0, 1, 8'd0, 4'd0), "hold1");
    vecs[6]  = mkv(0, 0, 0, 0, pk(0, 0, 0, 1, 8'd0, 4'd0), "hold2");
    vecs[7]  = mkv(0, 1, 0, 0, pk(0, 0, 0, 1, 8'd0, 4'd0), "hold3_start_ignored");
    vecs[8]  = mkv(0, 0, 0, 0, pk(0, 0, 0, 1, 8'd0, 4'd0), "hold4");
    vecs[9]  = mkv(0, 0, 0, 0, pk(1, 0, 0, 1, 8'd0, 4'd0), "run_entry");
    vecs[10] = mkv(0, 0, 0, 1, pk(1, 0, 0, 1, 8'd0, 4'd0), "sync_stage1");
    vecs[11] = mkv(0, 0, 0, 1, pk(1, 0, 0, 1, 8'd0, 4'd0), "sync_stage2");
    vecs[12] = mkv(0, 0, 0, 1, pk(1, 0, 0, 1, 8'd1, 4'd0), "edge_rise");
    vecs[13] = mkv(0, 0, 0, 0, pk(1, 0, 0, 1, 8'd1, 4'd0), "fall_stage1");
    vecs[14] = mkv(0, 0, 0, 0, pk(1, 0, 0, 1, 8'd1, 4'd0), "fall_stage2");
    vecs[15] = mkv(0, 0, 0, 0, pk(1, 0, 0, 1, 8'd2, 4'd0), "edge_fall");
    vecs[16] = mkv(0, 1, 0, 0, pk(1, 0, 0, 1, 8'd2, 4'd0), "run_start_ignored");
    vecs[17] = mkv(0, 0, 1, 0, pk(0, 0, 0, 0, 8'd0, 4'd0), "abort_run");
    vecs[18] = mkv(0, 0, 0, 0, pk(0, 0, 0, 0, 8'd0, 4'd0), "idle_after_abort");

    for (int v = 0; v < 19; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].st, vecs[v].sp, vecs[v].os);
      checkOutput(vecs[v].name, vecs[v].exp);
    end

    // Nominal lock: osc toggles every 5 cycles, each edge counted 2 cycles after it is driven
    oscv = 1'b0;
    lock_cyc = -1; lock_edges = -1;
    applyStimulus(0, 1, 0, oscv);
    checkOutput("a_hold_entry", pk(0, 0, 0, 1, 8'd0, 4'd0));
    for (int i = 1; i <= 60; i++) begin
      if (i % 5 == 0) oscv = ~oscv;
      applyStimulus(0, 0, 0, oscv);
      if (i == 3) checkValue("a_nreset_last_hold", 32'(n_reset), 32'd0);
      if (i == 4) checkValue("a_nreset_run", 32'(n_reset), 32'd1);
      if (locked && lock_cyc < 0) begin
        lock_cyc   = i;
        lock_edges = int'(edge_count);
      end
    end
    checkValue("a_lock_cycle", 32'(lock_cyc), 32'd42);
    checkValue("a_lock_edges", 32'(lock_edges), 32'd8);
    checkOutput("a_locked_steady", pk(1, 1, 0, 0, 8'd11, 4'd0));

    // Stall after lock: last edge counted at cycle 62, locked drops 64 cycles later
    fall_cyc = -1; relock_cyc = -1;
    fall_retry = -1; fall_busy = -1; fall_nr = -1; fall_edges = -1;
    for (int i = 61; i <= 200; i++) begin
      if (i >= 130 && i % 5 == 0) oscv = ~oscv;
      applyStimulus(0, 0, 0, oscv);
      if (i == 125) checkOutput("b_still_locked", pk(1, 1, 0, 0, 8'd12, 4'd0));
      if (!locked && fall_cyc < 0) begin
        fall_cyc   = i;
        fall_retry = int'(retry_count);
        fall_busy  = int'(busy);
        fall_nr    = int'(n_reset);
        fall_edges = int'(edge_count);
      end
      if (fall_cyc >= 0 && locked && relock_cyc < 0) relock_cyc = i;
    end
    checkValue("b_fall_cycle", 32'(fall_cyc), 32'd126);
    checkValue("b_fall_retry", 32'(fall_retry), 32'd1);
    checkValue("b_fall_busy", 32'(fall_busy), 32'd1);
    checkValue("b_fall_nreset", 32'(fall_nr), 32'd0);
    checkValue("b_fall_edges", 32'(fall_edges), 32'd0);
    checkValue("b_relock_cycle", 32'(relock_cyc), 32'd167);
    checkValue("b_relock_retry", 32'(retry_count), 32'd1);

    // Reset while LOCKED, then a clean restart
    oscv = 1'b0;
    applyStimulus(1, 0, 0, oscv);
    checkOutput("c_reset_in_locked", pk(0, 0, 0, 0, 8'd0, 4'd0));
    applyStimulus(0, 0, 0, oscv);
    checkOutput("c_idle_after_reset", pk(0, 0, 0, 0, 8'd0, 4'd0));

    // Stuck osc: three retries then FAIL
    r1_cyc = -1; r2_cyc = -1; r3_cyc = -1; fail_cyc = -1; fail_nr = -1; fail_busy = -1;
    applyStimulus(0, 1, 0, oscv);
    checkOutput("c_restart_hold", pk(0, 0, 0, 1, 8'd0, 4'd0));
    for (int j = 1; j <= 300; j++) begin
      applyStimulus(0, 0, 0, oscv);
      if (j == 4) checkOutput("c_restart_run", pk(1, 0, 0, 1, 8'd0, 4'd0));
      if (retry_count == 4'd1 && r1_cyc < 0) r1_cyc = j;
      if (retry_count == 4'd2 && r2_cyc < 0) r2_cyc = j;
      if (retry_count == 4'd3 && r3_cyc < 0) r3_cyc = j;
      if (fail && fail_cyc < 0) begin
        fail_cyc  = j;
        fail_nr   = int'(n_reset);
        fail_busy = int'(busy);
      end
    end
    checkValue("d_retry1_cycle", 32'(r1_cyc), 32'd68);
    checkValue("d_retry2_cycle", 32'(r2_cyc), 32'd136);
    checkValue("d_retry3_cycle", 32'(r3_cyc), 32'd204);
    checkValue("d_fail_cycle", 32'(fail_cyc), 32'd272);
    checkValue("d_fail_nreset", 32'(fail_nr), 32'd0);
    checkValue("d_fail_busy", 32'(fail_busy), 32'd0);

    // Start out of FAIL; an edge landing exactly on watchdog expiry must win
    applyStimulus(0, 1, 0, oscv);
    checkOutput("e_fail_restart", pk(0, 0, 0, 1, 8'd0, 4'd0));
    for (int k = 1; k <= 140; k++) begin
      oscv = (k >= 66) ? 1'b1 : 1'b0;
      applyStimulus(0, 0, 0, oscv);
      if (k == 68)  checkOutput("e_edge_beats_wd", pk(1, 0, 0, 1, 8'd1, 4'd0));
      if (k == 131) checkValue("e_no_stall_yet", 32'(retry_count), 32'd0);
      if (k == 132) checkOutput("e_stall_after_edge", pk(0, 0, 0, 1, 8'd0, 4'd1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
